cpri_txdata_pack: RTL and testbench

Per-lane CPRI transmit packer, the transmit-side counterpart of the lane receive/unpack path. It takes one symbol of per-antenna IQ samples plus symbol header fields and the FFT AGC byte, and serialises them into 64-bit CPRI words. The word stream carries a two-word header followed by ANT/2 words per IQ sample. One instance is placed per lane, ahead of the CPRI TX core.

---
 rtl/cpri_txdata_pack_if.sv | 37 +++
 rtl/cpri_txdata_pack.sv | 177 +++++++++++++++++
 tb/tb_cpri_txdata_pack.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpri_txdata_pack_if.sv
// Handshake and data bundle for the CPRI lane TX packer: header, IQ samples in, 64-bit words out.
// master drives the header/sample inputs and downstream ready; slave is the packer itself.
interface cpri_txdata_pack_if #(
  parameter int ANT = 4,
  parameter int AW  = 12
);
  logic                i_hdr_vld;
  logic                o_hdr_rdy;
  logic [3:0]          i_pkg_type;
  logic [6:0]          i_slot_idx;
  logic [3:0]          i_symb_idx;
  logic                i_cell_idx;
  logic [63:0]         i_info_0;
  logic [7:0]          i_info_1;
  logic [ANT*32-1:0]   i_iq_data;
  logic                i_iq_vld;
  logic                i_iq_last;
  logic                o_iq_rdy;
  logic [63:0]         o_tx_data;
  logic [AW-1:0]       o_tx_addr;
  logic                o_tx_vld;
  logic                o_tx_last;
  logic                i_tx_rdy;
  logic                o_len_err;

  modport master (
    output i_hdr_vld, i_pkg_type, i_slot_idx, i_symb_idx, i_cell_idx, i_info_0, i_info_1,
    output i_iq_data, i_iq_vld, i_iq_last, i_tx_rdy,
    input  o_hdr_rdy, o_iq_rdy, o_tx_data, o_tx_addr, o_tx_vld, o_tx_last, o_len_err
  );

  modport slave (
    input  i_hdr_vld, i_pkg_type, i_slot_idx, i_symb_idx, i_cell_idx, i_info_0, i_info_1,
    input  i_iq_data, i_iq_vld, i_iq_last, i_tx_rdy,
    output o_hdr_rdy, o_iq_rdy, o_tx_data, o_tx_addr, o_tx_vld, o_tx_last, o_len_err
  );
endinterface

// File: rtl/cpri_txdata_pack.sv
// Packs one symbol (2 header words + ANT/2 words per IQ sample) into 64-bit CPRI words; HDR0 valid 1 cycle after header accept.
// Output words are registered-stable under i_tx_rdy backpressure; a one-sample buffer refills with no bubble when ready stays high.
module cpri_txdata_pack #(
  parameter int ANT     = 4,
  parameter int SAMPLES = 1584,
  parameter int AW      = 12
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  cpri_txdata_pack_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, IQ} state_e;

  localparam int HALF = ANT / 2;
  localparam int WW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [WW-1:0] W_LAST   = WW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assertion is immediate; release is aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [3:0]        pkg_q, pkg_d;
  logic [6:0]        slot_q, slot_d;
  logic [3:0]        symb_q, symb_d;
  logic              cell_q, cell_d;
  logic [47:0]       info0_q, info0_d;
  logic [7:0]        info1_q, info1_d;
  logic [ANT*32-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic              blast_q, blast_d;
  logic [WW-1:0]     w_q, w_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;

  logic        tx_vld, tx_xfer, tx_last, iq_rdy, iq_acc, eos, len_err;
  logic [63:0] tx_data;
  logic        info0_unused;

  assign info0_unused = ^bus.i_info_0[63:48];

  always_comb begin
    tx_vld  = (state_q == HDR0) || (state_q == HDR1) || ((state_q == IQ) && full_q);
    tx_xfer = tx_vld && bus.i_tx_rdy;
    tx_last = (state_q == IQ) && full_q && blast_q && (w_q == W_LAST);
    // The final word of a symbol must not pull in a sample that belongs to the next one.
    iq_rdy  = (state_q == IQ) &&
              (!full_q || ((w_q == W_LAST) && tx_xfer && !blast_q));
    iq_acc  = bus.i_iq_vld && iq_rdy;
    eos     = bus.i_iq_last || (cnt_q == CNT_LAST);
    len_err = iq_acc && (bus.i_iq_last ? (cnt_q != CNT_LAST) : (cnt_q == CNT_LAST));

    tx_data = '0;
    case (state_q)
      HDR0:    tx_data = {pkg_q, slot_q, symb_q, cell_q, info0_q};
      HDR1:    tx_data = {56'b0, info1_q};
      IQ:      if (full_q) tx_data = buf_q[{w_q, 6'b0} +: 64];
      default: tx_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pkg_d   = pkg_q;
    slot_d  = slot_q;
    symb_d  = symb_q;
    cell_d  = cell_q;
    info0_d = info0_q;
    info1_d = info1_q;
    buf_d   = buf_q;
    full_d  = full_q;
    blast_d = blast_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        if (bus.i_hdr_vld) begin
          pkg_d   = bus.i_pkg_type;
          slot_d  = bus.i_slot_idx;
          symb_d  = bus.i_symb_idx;
          cell_d  = bus.i_cell_idx;
          info0_d = bus.i_info_0[47:0];
          info1_d = bus.i_info_1;
          addr_d  = '0;
          state_d = HDR0;
        end
      end
      HDR0: begin
        if (tx_xfer) begin
          addr_d  = addr_q + AW'(1);
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (tx_xfer) begin
          addr_d  = addr_q + AW'(1);
          state_d = IQ;
        end
      end
      IQ: begin
        if (tx_xfer) begin
          addr_d = addr_q + AW'(1);
          if (w_q == W_LAST) begin
            w_d    = '0;
            full_d = 1'b0;
            if (blast_q) begin
              blast_d = 1'b0;
              addr_d  = '0;
              state_d = IDLE;
            end
          end else begin
            w_d = w_q + WW'(1);
          end
        end
        if (iq_acc) begin
          buf_d   = bus.i_iq_data;
          full_d  = 1'b1;
          blast_d = eos;
          cnt_d   = eos ? '0 : cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pkg_q   <= '0;
      slot_q  <= '0;
      symb_q  <= '0;
      cell_q  <= 1'b0;
      info0_q <= '0;
      info1_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      blast_q <= 1'b0;
      w_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pkg_q   <= pkg_d;
      slot_q  <= slot_d;
      symb_q  <= symb_d;
      cell_q  <= cell_d;
      info0_q <= info0_d;
      info1_q <= info1_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      blast_q <= blast_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.o_hdr_rdy = (state_q == IDLE);
  assign bus.o_iq_rdy  = iq_rdy;
  assign bus.o_tx_data = tx_data;
  assign bus.o_tx_addr = addr_q;
  assign bus.o_tx_vld  = tx_vld;
  assign bus.o_tx_last = tx_last;
  assign bus.o_len_err = len_err;

endmodule

// File: tb/tb_cpri_txdata_pack.sv
// Directed bench for cpri_txdata_pack: nominal, random ready, early/missing last, back-to-back and mid-symbol reset.
module tb_cpri_txdata_pack;
  localparam int ANT     = 4;
  localparam int SAMPLES = 1584;
  localparam int AW      = 12;
  localparam int HALF    = ANT / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpri_txdata_pack_if #(.ANT(ANT), .AW(AW)) bus ();

  cpri_txdata_pack #(.ANT(ANT), .SAMPLES(SAMPLES), .AW(AW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  h_pkg;
  logic [6:0]  h_slot;
  logic [3:0]  h_symb;
  logic        h_cell;
  logic [63:0] h_info0;
  logic [7:0]  h_agc;
  logic [63:0] exp_hdr0;
  int          sym_id = 0;
  int          last_xfer_cyc = -100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ant_val(input int s, input int k);
    return {8'(sym_id) ^ 8'hC3, 8'(k) | 8'h40, 16'(s)};
  endfunction

  function automatic logic [63:0] exp_word(input int e);
    int k, w;
    if (e == 0) return exp_hdr0;
    if (e == 1) return {56'b0, h_agc};
    k = (e - 2) / HALF;
    w = (e - 2) % HALF;
    return {ant_val(k, 2*w + 1), ant_val(k, 2*w)};
  endfunction

  task automatic idle_inputs();
    bus.i_hdr_vld  = 1'b0;
    bus.i_pkg_type = '0;
    bus.i_slot_idx = '0;
    bus.i_symb_idx = '0;
    bus.i_cell_idx = 1'b0;
    bus.i_info_0   = '0;
    bus.i_info_1   = '0;
    bus.i_iq_data  = '0;
    bus.i_iq_vld   = 1'b0;
    bus.i_iq_last  = 1'b0;
    bus.i_tx_rdy   = 1'b1;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_tx_vld"},  64'(bus.o_tx_vld),  64'd0);
    chk({pfx, "_tx_last"}, 64'(bus.o_tx_last), 64'd0);
    chk({pfx, "_tx_data"}, bus.o_tx_data,      64'd0);
    chk({pfx, "_tx_addr"}, 64'(bus.o_tx_addr), 64'd0);
    chk({pfx, "_len_err"}, 64'(bus.o_len_err), 64'd0);
    chk({pfx, "_hdr_rdy"}, 64'(bus.o_hdr_rdy), 64'd1);
    chk({pfx, "_iq_rdy"},  64'(bus.o_iq_rdy),  64'd0);
  endtask

  // last_at < 0 means no i_iq_last; abort_at >= 0 pulls reset when that word index is presented.
  task automatic run_symbol(input int nsamp, input int last_at, input bit rnd, input bit b2b,
                            input int abort_at, input bit hold);
    int si, ei, neff, nwords, lerr, budget, first_cyc, last_cyc, hdr_cyc, acc0_cyc;
    bit hdr_done, stall, aborted, exp_err, exp_le;
    logic [63:0]   s_dat;
    logic [AW-1:0] s_addr;
    si = 0; ei = 0; lerr = 0; budget = 0;
    first_cyc = 0; last_cyc = 0; hdr_cyc = -10; acc0_cyc = -10;
    hdr_done = 1'b0; stall = 1'b0; aborted = 1'b0;
    s_dat = '0; s_addr = '0;
    neff    = (last_at >= 0) ? last_at + 1 : SAMPLES;
    nwords  = neff * HALF + 2;
    exp_err = (last_at != SAMPLES - 1);

    while (ei < nwords) begin
      @(negedge clk);
      budget++;
      if (budget > 4 * nwords + 50) begin
        chk("timeout_words", 64'(ei), 64'(nwords));
        break;
      end
      bus.i_tx_rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_hdr_vld  = hold ? 1'b1 : !hdr_done;
      bus.i_pkg_type = h_pkg;
      bus.i_slot_idx = h_slot;
      bus.i_symb_idx = h_symb;
      bus.i_cell_idx = h_cell;
      bus.i_info_0   = h_info0;
      bus.i_info_1   = h_agc;
      bus.i_iq_vld   = hdr_done && (si < nsamp);
      bus.i_iq_last  = (si == last_at);
      for (int k = 0; k < ANT; k++) bus.i_iq_data[32*k +: 32] = ant_val(si, k);
      #1;

      if (abort_at >= 0 && ei == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        aborted = 1'b1;
        break;
      end

      if (cyc == hdr_cyc + 1) begin
        chk("hdr0_vld",  64'(bus.o_tx_vld),  64'd1);
        chk("hdr0_addr", 64'(bus.o_tx_addr), 64'd0);
      end
      if (cyc == acc0_cyc + 1) begin
        chk("iq0_vld",  64'(bus.o_tx_vld),  64'd1);
        chk("iq0_addr", 64'(bus.o_tx_addr), 64'd2);
      end
      if (stall) begin
        chk("hold_data", bus.o_tx_data, s_dat);
        chk("hold_addr", 64'(bus.o_tx_addr), 64'(s_addr));
      end
      if (!bus.i_tx_rdy && bus.o_tx_vld && ei >= 2)
        chk("bp_iq_rdy", 64'(bus.o_iq_rdy), 64'd0);
      if (bus.o_len_err) lerr++;

      if (!hdr_done && bus.i_hdr_vld && bus.o_hdr_rdy) begin
        hdr_done = 1'b1;
        hdr_cyc  = cyc;
        if (b2b) chk("b2b_gap", 64'(cyc - last_xfer_cyc), 64'd1);
      end
      if (bus.i_iq_vld && bus.o_iq_rdy) begin
        exp_le = (si == last_at && si < SAMPLES - 1) || (si == SAMPLES - 1 && si != last_at);
        chk("len_err_at_acc", 64'(bus.o_len_err), 64'(exp_le));
        if (si == 0) acc0_cyc = cyc;
        si++;
      end

      stall  = bus.o_tx_vld && !bus.i_tx_rdy;
      s_dat  = bus.o_tx_data;
      s_addr = bus.o_tx_addr;
      if (bus.o_tx_vld && bus.i_tx_rdy) begin
        chk("addr", 64'(bus.o_tx_addr), 64'(ei));
        chk("data", bus.o_tx_data, exp_word(ei));
        chk("last", 64'(bus.o_tx_last), 64'(ei == nwords - 1));
        if (ei == 0) first_cyc = cyc;
        last_cyc = cyc;
        ei++;
      end
    end
    last_xfer_cyc = last_cyc;

    if (aborted) begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_hold_vld", 64'(bus.o_tx_vld), 64'd0);
      idle_inputs();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      chk("len_err_pulses", 64'(lerr), 64'(exp_err));
      // With ready held high the only gap is the cycle that loads sample 0 after HDR1.
      if (!rnd) chk("span_cycles", 64'(last_cyc - first_cyc), 64'(nwords));
      if (!hold) begin
        @(negedge clk);
        idle_inputs();
        #1;
        chk("end_hdr_rdy", 64'(bus.o_hdr_rdy), 64'd1);
        chk("end_tx_vld",  64'(bus.o_tx_vld),  64'd0);
      end
    end
  endtask

  task automatic set_hdr_a();
    h_pkg = 4'h3; h_slot = 7'd5; h_symb = 4'd2; h_cell = 1'b1;
    h_info0 = 64'h1234_5678_9ABC_BEEF; h_agc = 8'h2A;
    exp_hdr0 = 64'h30A5_5678_9ABC_BEEF;
  endtask

  task automatic set_hdr_b();
    h_pkg = 4'hA; h_slot = 7'd127; h_symb = 4'd13; h_cell = 1'b0;
    h_info0 = 64'hFFFF_0000_1111_2222; h_agc = 8'hD7;
    exp_hdr0 = 64'hAFFA_0000_1111_2222;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    set_hdr_a(); sym_id = 1;
    run_symbol(SAMPLES, SAMPLES - 1, 1'b0, 1'b0, -1, 1'b0);

    run_symbol(SAMPLES, SAMPLES - 1, 1'b1, 1'b0, -1, 1'b0);

    sym_id = 2;
    run_symbol(100, 99, 1'b0, 1'b0, -1, 1'b0);

    sym_id = 3;
    run_symbol(SAMPLES, -1, 1'b0, 1'b0, -1, 1'b0);

    sym_id = 4;
    run_symbol(SAMPLES, SAMPLES - 1, 1'b0, 1'b0, -1, 1'b1);
    set_hdr_b(); sym_id = 5;
    run_symbol(SAMPLES, SAMPLES - 1, 1'b0, 1'b1, -1, 1'b0);

    set_hdr_a(); sym_id = 6;
    run_symbol(SAMPLES, SAMPLES - 1, 1'b0, 1'b0, 500, 1'b0);
    sym_id = 7;
    run_symbol(SAMPLES, SAMPLES - 1, 1'b0, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
